dmac_burst_arbiter: RTL and testbench

- Parametrised N-to-1 round-robin arbiter for the DMAC data path. It is the next generation of the fixed 4-channel arbiter.
- Arbitrates whole bursts: once a master wins, the grant is held until that master's beat flagged last is accepted.
- Adds a registered output stage and reports the winning master's index with every beat.

---
 rtl/dmac_arb_pkg.sv | 11 +
 rtl/dmac_rr_pick.sv | 28 ++
 rtl/dmac_burst_arbiter.sv | 84 ++++++++
 tb/tb_dmac_burst_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_arb_pkg.sv
// dmac_arb_pkg: shared types and helpers for the DMAC arbiters
package dmac_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Id width for n masters, never narrower than one bit
    function automatic int arb_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// dmac_rr_pick: combinational rotating-priority picker starting after last_grant
module dmac_rr_pick
    import dmac_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = arb_id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] pick,
    output logic          any_req
);

    logic [IW:0] idx;

    // Scan from the farthest slot back toward last_grant+1 so the nearest requester wins
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_req = |req;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, last_grant} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (req[idx[IW-1:0]]) pick = idx[IW-1:0];
        end
    end

endmodule

// File: rtl/dmac_burst_arbiter.sv
// dmac_burst_arbiter: N-to-1 round-robin burst arbiter with a registered output stage
module dmac_burst_arbiter
    import dmac_arb_pkg::*;
#(
    parameter  int N_MASTER  = 4,
    parameter  int DATA_SIZE = 32,
    localparam int ID_W      = arb_id_w(N_MASTER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_valid_i [N_MASTER],
    output logic                 src_ready_o [N_MASTER],
    input  logic [DATA_SIZE-1:0] src_data_i  [N_MASTER],
    input  logic                 src_last_i  [N_MASTER],
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [DATA_SIZE-1:0] dst_data_o,
    output logic                 dst_last_o,
    output logic [ID_W-1:0]      dst_id_o
);

    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic                 dst_valid_q, dst_valid_d;
    logic [DATA_SIZE-1:0] dst_data_q, dst_data_d;
    logic                 dst_last_q, dst_last_d;
    logic [ID_W-1:0]      dst_id_q, dst_id_d;
    logic [N_MASTER-1:0]  valid_vec;
    logic [ID_W-1:0]      pick, sel;
    logic                 any_req, can_load, active, xfer;

    // Flatten the per-master valids for the picker
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < N_MASTER; i++) valid_vec[i] = src_valid_i[i];
    end

    dmac_rr_pick #(.N(N_MASTER)) u_pick (
        .req        (valid_vec),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any_req    (any_req)
    );

    // While locked the owner is last_grant, since the pointer moves only on grant
    always_comb begin
        can_load     = !dst_valid_q || dst_ready_i;
        sel          = (state_q == LOCKED) ? last_grant_q : pick;
        active       = (state_q == LOCKED) || any_req;
        xfer         = active && can_load && valid_vec[sel];
        for (int i = 0; i < N_MASTER; i++) src_ready_o[i] = rst_n && active && can_load && (sel == ID_W'(i));
        state_d      = xfer ? (src_last_i[sel] ? IDLE : LOCKED) : state_q;
        last_grant_d = xfer ? sel : last_grant_q;
        dst_valid_d  = xfer || (dst_valid_q && !dst_ready_i);
        dst_data_d   = xfer ? src_data_i[sel] : dst_data_q;
        dst_last_d   = xfer ? src_last_i[sel] : dst_last_q;
        dst_id_d     = xfer ? sel : dst_id_q;
    end

    // Arbitration state and output register, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_MASTER - 1);
            dst_valid_q  <= 1'b0;
            dst_data_q   <= '0;
            dst_last_q   <= 1'b0;
            dst_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dst_valid_q  <= dst_valid_d;
            dst_data_q   <= dst_data_d;
            dst_last_q   <= dst_last_d;
            dst_id_q     <= dst_id_d;
        end
    end

    assign dst_valid_o = dst_valid_q;
    assign dst_data_o  = dst_data_q;
    assign dst_last_o  = dst_last_q;
    assign dst_id_o    = dst_id_q;

endmodule

// File: tb/tb_dmac_burst_arbiter.sv
// tb_dmac_burst_arbiter: directed and random checks of the burst arbiter against a reference model
module tb_dmac_burst_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct { int id; logic [31:0] d; } beat_t;

    logic clk = 0, rst_n = 0, rst1_n = 0, one = 1;
    always #5 clk = ~clk;

    logic          vld [N], rdy [N], lst [N];
    logic [DW-1:0] dat [N];
    logic          dst_valid, dst_ready = 1, dst_last;
    logic [DW-1:0] dst_data;
    logic [1:0]    dst_id;

    logic        v8 [8], r8 [8], l8 [8];
    logic [31:0] d8 [8];
    logic        o8_v, o8_l;
    logic [31:0] o8_d;
    logic [2:0]  o8_id;
    logic        v1 [1], r1 [1], l1 [1];
    logic [31:0] d1 [1];
    logic        o1_v, o1_l;
    logic [31:0] o1_d;
    logic [0:0]  o1_id;

    dmac_burst_arbiter #(.N_MASTER(N), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid_i(vld), .src_ready_o(rdy), .src_data_i(dat),
        .src_last_i(lst), .dst_valid_o(dst_valid), .dst_ready_i(dst_ready), .dst_data_o(dst_data),
        .dst_last_o(dst_last), .dst_id_o(dst_id)
    );

    dmac_burst_arbiter #(.N_MASTER(8), .DATA_SIZE(32)) dut8 (
        .clk(clk), .rst_n(rst1_n), .src_valid_i(v8), .src_ready_o(r8), .src_data_i(d8),
        .src_last_i(l8), .dst_valid_o(o8_v), .dst_ready_i(one), .dst_data_o(o8_d),
        .dst_last_o(o8_l), .dst_id_o(o8_id)
    );

    dmac_burst_arbiter #(.N_MASTER(1), .DATA_SIZE(32)) dut1 (
        .clk(clk), .rst_n(rst1_n), .src_valid_i(v1), .src_ready_o(r1), .src_data_i(d1),
        .src_last_i(l1), .dst_valid_o(o1_v), .dst_ready_i(one), .dst_data_o(o1_d),
        .dst_last_o(o1_l), .dst_id_o(o1_id)
    );

    int checks = 0, errors = 0;
    beat_t log_q[$], q8[$], q1[$];

    int          ptr = N - 1, owner = 0, mid = 0;
    bit          locked = 0, mv = 0, ml = 0;
    logic [31:0] md = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = rdy[i];
        return r;
    endfunction

    // Reference model: one output slot, a rotating pointer and an optional burst owner
    always @(negedge clk) begin
        logic [3:0]  er;
        logic [35:0] eo;
        int          w;
        bit          room;
        if (!rst_n) begin
            ptr = N - 1; locked = 0; mv = 0; ml = 0; md = 0; mid = 0;
            chk("rst_ready", rdy_vec(), 0);
            chk("rst_out", {dst_valid, dst_last, dst_id, dst_data}, 0);
        end else begin
            eo = {mv, ml, 2'(mid), md};
            chk("out", {dst_valid, dst_last, dst_id, dst_data}, eo);
            if (dst_valid && dst_ready) log_q.push_back('{int'(dst_id), dst_data});
            room = !mv || dst_ready;
            w = -1;
            if (locked) w = owner;
            else for (int j = 1; j <= N; j++) if (w < 0 && vld[(ptr + j) % N]) w = (ptr + j) % N;
            er = 0;
            if (room && w >= 0) er[w] = 1'b1;
            chk("ready", rdy_vec(), er);
            if (room && w >= 0 && vld[w]) begin
                md = dat[w]; ml = lst[w]; mid = w; mv = 1;
                ptr = w; owner = w; locked = !lst[w];
            end else if (mv && dst_ready) mv = 0;
        end
    end

    always @(negedge clk) begin
        if (rst1_n && o8_v && q8.size() < 16) q8.push_back('{int'(o8_id), o8_d});
        if (rst1_n && o1_v && q1.size() < 16) q1.push_back('{int'(o1_id), o1_d});
    end

    task automatic check_log(input string nm, input int n, input int ids [8], input logic [31:0] ds [8]);
        chk({nm, "_len"}, 64'(log_q.size() >= n), 1);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk({nm, "_id"}, log_q[i].id, ids[i]);
            chk({nm, "_data"}, log_q[i].d, ds[i]);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin vld[i] = 0; lst[i] = 0; dat[i] = 0; end
    endtask

    task automatic run_singles(input logic [3:0] m);
        logic [3:0] pend;
        pend = m;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin vld[i] = pend[i]; lst[i] = 1; dat[i] = 32'h50 + i; end
        for (int c = 0; c < 30 && pend != 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (vld[i] && rdy[i]) pend[i] = 0;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) vld[i] = pend[i];
        end
        chk("singles_done", pend, 0);
    endtask

    initial begin
        int       b, gap;
        bit       saw2, done1, acc;
        int       rem [N];
        bit       a [N];
        clear_inputs();
        for (int i = 0; i < 8; i++) begin v8[i] = 1; l8[i] = 1; d8[i] = 32'hA0 + i; end
        v1[0] = 1; l1[0] = 1; d1[0] = 32'hA0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; rst1_n = 1;

        // idle after reset
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", rdy_vec(), 0);
            chk("idle_valid", dst_valid, 0);
        end

        // all masters single-beat, round-robin from master 0
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin vld[i] = 1; lst[i] = 1; dat[i] = 32'hA0 + i; end
        log_q.delete();
        repeat (7) @(posedge clk);
        check_log("rr4", 5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 0, 0, 0});
        chk("n8_len", 64'(q8.size() >= 9), 1);
        for (int i = 0; i < 9 && i < q8.size(); i++) begin
            chk("n8_id", q8[i].id, i % 8);
            chk("n8_data", q8[i].d, 32'hA0 + (i % 8));
        end
        chk("n1_len", 64'(q1.size() >= 3), 1);
        for (int i = 0; i < 3 && i < q1.size(); i++) begin
            chk("n1_id", q1[i].id, 0);
            chk("n1_data", q1[i].d, 32'hA0);
        end

        // reset asserted mid-cycle clears the output before the next edge
        #1 chk("pre_rst_valid", dst_valid, 1);
        #1 rst_n = 0;
        #1 chk("async_rst_valid", dst_valid, 0);
        chk("async_rst_ready", rdy_vec(), 0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // master 1 burst with a gap, master 2 waiting
        @(posedge clk); #1;
        vld[1] = 1; dat[1] = 32'h10; lst[1] = 0;
        log_q.delete();
        b = 0; gap = 0; saw2 = 0; done1 = 0;
        for (int cyc = 0; cyc < 40 && !done1; cyc++) begin
            @(negedge clk);
            acc = vld[1] && rdy[1];
            if (rdy[2]) saw2 = 1;
            @(posedge clk); #1;
            vld[2] = 1; dat[2] = 32'h20; lst[2] = 1;
            if (acc) begin
                b++;
                if (b == 4) begin vld[1] = 0; done1 = 1; end
                else if (b == 2) begin vld[1] = 0; gap = 2; end
                else begin dat[1] = 32'h10 + b; lst[1] = (b == 3); end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) begin vld[1] = 1; dat[1] = 32'h12; lst[1] = 0; end
            end
        end
        chk("burst_done", done1, 1);
        chk("m2_blocked", saw2, 0);
        repeat (2) @(posedge clk);
        #1 vld[2] = 0;
        repeat (2) @(posedge clk);
        check_log("burst", 5, '{1, 1, 1, 1, 2, 0, 0, 0}, '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 0, 0, 0});

        // backpressure holds the output register and blocks all sources
        @(posedge clk); #1;
        vld[0] = 1; lst[0] = 1; dat[0] = 32'h40; dst_ready = 1;
        @(posedge clk); #1;
        dat[0] = 32'h41; dst_ready = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_data", dst_data, 32'h40);
            chk("stall_valid", dst_valid, 1);
            chk("stall_ready", rdy_vec(), 0);
            @(posedge clk); #1;
            if (s == 0) dat[0] = 32'h42;
        end
        dst_ready = 1;
        @(negedge clk);
        chk("release_data", dst_data, 32'h40);
        chk("release_ready", rdy_vec(), 4'b0001);
        @(posedge clk); #1 vld[0] = 0;
        @(negedge clk);
        chk("next_beat", {dst_valid, dst_data}, {1'b1, 32'h42});
        repeat (2) @(posedge clk);

        // wrap from master 3 to master 0 before master 2
        log_q.delete();
        run_singles(4'b1000);
        run_singles(4'b0101);
        repeat (2) @(posedge clk);
        check_log("wrap", 3, '{3, 0, 2, 0, 0, 0, 0, 0}, '{32'h53, 32'h50, 32'h52, 0, 0, 0, 0, 0});

        // reset in the middle of a master 2 burst
        clear_inputs();
        @(posedge clk); #1;
        vld[2] = 1; dat[2] = 32'h60; lst[2] = 0;
        b = 0;
        for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
            @(negedge clk);
            if (vld[2] && rdy[2]) b++;
            @(posedge clk); #1;
            dat[2] = 32'h60 + b;
        end
        chk("m2_two_beats", b, 2);
        #1 rst_n = 0;
        dat[2] = 32'h60; lst[2] = 1;
        vld[0] = 1; lst[0] = 1; dat[0] = 32'h70;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        log_q.delete();
        @(negedge clk);
        chk("post_rst_pick", rdy_vec(), 4'b0001);
        @(posedge clk); #1 vld[0] = 0;
        @(posedge clk); #1 vld[2] = 0;
        repeat (3) @(posedge clk);
        check_log("post_rst", 2, '{0, 2, 0, 0, 0, 0, 0, 0}, '{32'h70, 32'h60, 0, 0, 0, 0, 0, 0});

        // random bursts, gaps, backpressure and occasional resets
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) a[i] = vld[i] && rdy[i];
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (a[i] && rem[i] > 0) rem[i]--;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                for (int i = 0; i < N; i++) rem[i] = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 5);
                vld[i] = rem[i] > 0 && $urandom_range(0, 4) != 0;
                lst[i] = rem[i] == 1;
                dat[i] = $urandom;
            end
            dst_ready = $urandom_range(0, 3) != 0;
        end
        rst_n = 1;
        clear_inputs();
        dst_ready = 1;
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
